kch_collect_ctrl: RTL and testbench

Sequencer for the known-cluster-head store (`knownCH_small`) in the EER-RL node datapath. It accepts parsed heartbeat (HB) and cluster-head (CHE) packet fields from the receive path over a valid/ready handshake. It generates the store's `HB_reset` and `en_KCH` strobes with stable `fCH_*` operands, filters invalid or excess advertisements, and enforces a collection window and CH limit. It latches the store's final `chosenCH`/`hopsFromCH` for the routing FSM.

---
 rtl/kch_collect_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_kch_collect_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kch_collect_ctrl.sv
// ---------------------------------------------------------------------------
// kch_collect_ctrl
//
// Sequencer for the known-cluster-head store (knownCH_small). Heartbeat (HB)
// packets open a collection round: the store is cleared with kch_HB_reset,
// the CH limit and the collection window are latched, and the window timer
// starts. Cluster-head (CHE) advertisements received during the round are
// filtered and then presented to the store one at a time with a one-cycle
// kch_en strobe. The operands are held for SETTLE_CYCLES cycles afterwards
// so the store's comparison can complete. The round ends when the CH limit
// is reached or the window expires. The store's chosen CH is then latched
// for the routing FSM.
//
// Ports:
//   clk, nrst                         clock, asynchronous active-low reset
//   pkt_valid / pkt_ready             packet handshake from the receive path
//   pkt_type                          0 = HB, 1 = CHE, others ignored
//   pkt_srcID, pkt_hops, pkt_QValue   advertised CH fields
//   myNodeID                          own node ID (self-adverts are dropped)
//   HB_CHlimit                        CHs per round, 0 = unlimited
//   collect_window                    round length in cycles, 0 = no timeout
//   kch_HB_reset, kch_en              strobes to the store
//   kch_fCH_ID/Hops/QValue            operands to the store
//   kch_chosenCH, kch_hopsFromCH      results from the store
//   selCH, selHops, sel_valid         selection latched at end of round
//   ch_count                          CHs issued this round
//   busy                              high outside IDLE and DONE
// ---------------------------------------------------------------------------
module kch_collect_ctrl #(
    parameter int WORD_WIDTH    = 16,
    parameter int TIMER_WIDTH   = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   pkt_valid,
    output logic                   pkt_ready,
    input  logic [1:0]             pkt_type,
    input  logic [WORD_WIDTH-1:0]  pkt_srcID,
    input  logic [WORD_WIDTH-1:0]  pkt_hops,
    input  logic [WORD_WIDTH-1:0]  pkt_QValue,
    input  logic [WORD_WIDTH-1:0]  myNodeID,
    input  logic [WORD_WIDTH-1:0]  HB_CHlimit,
    input  logic [TIMER_WIDTH-1:0] collect_window,
    output logic                   kch_HB_reset,
    output logic                   kch_en,
    output logic [WORD_WIDTH-1:0]  kch_fCH_ID,
    output logic [WORD_WIDTH-1:0]  kch_fCH_Hops,
    output logic [WORD_WIDTH-1:0]  kch_fCH_QValue,
    input  logic [WORD_WIDTH-1:0]  kch_chosenCH,
    input  logic [WORD_WIDTH-1:0]  kch_hopsFromCH,
    output logic [WORD_WIDTH-1:0]  selCH,
    output logic [WORD_WIDTH-1:0]  selHops,
    output logic                   sel_valid,
    output logic [WORD_WIDTH-1:0]  ch_count,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COLLECT,
        S_ISSUE,
        S_SETTLE,
        S_DONE
    } state_t;

    // Hop count meaning "unreachable"; also the store's empty value.
    localparam logic [WORD_WIDTH-1:0] HOPS_NONE   = '1;
    localparam logic [3:0]            SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t                 r_state;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_hbReset;
    logic                   r_kchEn;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic [TIMER_WIDTH-1:0] r_window;
    logic [WORD_WIDTH-1:0]  r_limit;
    logic [3:0]             r_settleCnt;
    logic [WORD_WIDTH-1:0]  r_fchID;
    logic [WORD_WIDTH-1:0]  r_fchHops;
    logic [WORD_WIDTH-1:0]  r_fchQ;
    logic [WORD_WIDTH-1:0]  r_selCH;
    logic [WORD_WIDTH-1:0]  r_selHops;
    logic                   r_selValid;
    logic [WORD_WIDTH-1:0]  r_chCount;

    logic   w_accept;
    logic   w_isHB;
    logic   w_isCHE;
    logic   w_expired;
    logic   w_limitHit;
    logic   w_cheOk;
    state_t w_nextState;

    // Handshake and round-status decode. The limit check uses the count of
    // CHs already issued, so it is also valid in SETTLE after the increment.
    assign w_accept   = pkt_valid & r_ready;
    assign w_isHB     = (pkt_type == 2'd0);
    assign w_isCHE    = (pkt_type == 2'd1);
    assign w_expired  = (r_timer == '0) && (r_window != '0);
    assign w_limitHit = (r_limit != '0) && (r_chCount == r_limit);
    assign w_cheOk    = (pkt_srcID != myNodeID) && (pkt_hops != HOPS_NONE) && !w_limitHit;

    // Next-state selection. In COLLECT a transfer always takes priority over
    // timer expiry; a dropped CHE simply leaves expiry to the next cycle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_isHB) w_nextState = S_CLEAR;
            end
            S_CLEAR: begin
                w_nextState = S_COLLECT;
            end
            S_COLLECT: begin
                if (w_accept) begin
                    if (w_isHB)                    w_nextState = S_CLEAR;
                    else if (w_isCHE && w_cheOk)   w_nextState = S_ISSUE;
                end else if (w_expired) begin
                    w_nextState = S_DONE;
                end
            end
            S_ISSUE: begin
                w_nextState = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_settleCnt == 4'd0)
                    w_nextState = (w_limitHit || w_expired) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                if (w_accept && w_isHB) w_nextState = S_CLEAR;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // State register plus all datapath registers. Handshake and strobe
    // outputs are registered from the next state so they are glitch-free
    // and drop immediately on an asynchronous abort.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_hbReset   <= 1'b0;
            r_kchEn     <= 1'b0;
            r_timer     <= '0;
            r_window    <= '0;
            r_limit     <= '0;
            r_settleCnt <= 4'd0;
            r_fchID     <= '0;
            r_fchHops   <= HOPS_NONE;
            r_fchQ      <= '0;
            r_selCH     <= '0;
            r_selHops   <= HOPS_NONE;
            r_selValid  <= 1'b0;
            r_chCount   <= '0;
        end else begin
            r_state   <= w_nextState;
            r_ready   <= (w_nextState == S_IDLE) || (w_nextState == S_COLLECT) ||
                         (w_nextState == S_DONE);
            r_busy    <= (w_nextState != S_IDLE) && (w_nextState != S_DONE);
            r_hbReset <= (w_nextState == S_CLEAR);
            r_kchEn   <= (w_nextState == S_ISSUE);

            // Round parameters are captured with the HB so a later change on
            // the inputs cannot disturb a round in progress.
            if (w_accept && w_isHB) begin
                r_limit  <= HB_CHlimit;
                r_window <= collect_window;
            end

            // Window timer runs through collection, issue and settling.
            case (r_state)
                S_CLEAR: r_timer <= r_window;
                S_COLLECT, S_ISSUE, S_SETTLE: begin
                    if (r_timer != '0) r_timer <= r_timer - TIMER_WIDTH'(1);
                end
                default: r_timer <= r_timer;
            endcase

            if (r_state == S_CLEAR) begin
                r_chCount  <= '0;
                r_selValid <= 1'b0;
            end else if (r_state == S_ISSUE) begin
                r_chCount  <= r_chCount + WORD_WIDTH'(1);
            end

            if (r_state == S_ISSUE)
                r_settleCnt <= SETTLE_LOAD;
            else if (r_state == S_SETTLE && r_settleCnt != 4'd0)
                r_settleCnt <= r_settleCnt - 4'd1;

            // Operands only move on a CHE that is actually issued.
            if (w_nextState == S_ISSUE && r_state == S_COLLECT) begin
                r_fchID   <= pkt_srcID;
                r_fchHops <= pkt_hops;
                r_fchQ    <= pkt_QValue;
            end

            // Capture the store's answer once, on the way into DONE.
            if (w_nextState == S_DONE && r_state != S_DONE) begin
                r_selCH    <= kch_chosenCH;
                r_selHops  <= kch_hopsFromCH;
                r_selValid <= (r_chCount != '0);
            end
        end
    end

    assign pkt_ready      = r_ready;
    assign busy           = r_busy;
    assign kch_HB_reset   = r_hbReset;
    assign kch_en         = r_kchEn;
    assign kch_fCH_ID     = r_fchID;
    assign kch_fCH_Hops   = r_fchHops;
    assign kch_fCH_QValue = r_fchQ;
    assign selCH          = r_selCH;
    assign selHops        = r_selHops;
    assign sel_valid      = r_selValid;
    assign ch_count       = r_chCount;

endmodule

// File: tb/tb_kch_collect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_kch_collect_ctrl
//
// Directed and randomized bench for kch_collect_ctrl. A small behavioural
// stand-in for knownCH_small (best = fewest hops, ties to higher Q) drives
// the store results. Expected behaviour is tracked per transaction: round
// open/closed, CHs issued, last issued operands, best CH so far and the
// number of strobes the controller should have produced.
// ---------------------------------------------------------------------------
module tb_kch_collect_ctrl;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        pkt_valid = 1'b0;
    logic        pkt_ready;
    logic [1:0]  pkt_type = 2'd0;
    logic [15:0] pkt_srcID = '0;
    logic [15:0] pkt_hops = '0;
    logic [15:0] pkt_QValue = '0;
    logic [15:0] myNodeID = 16'd12;
    logic [15:0] HB_CHlimit = '0;
    logic [15:0] collect_window = '0;
    logic        kch_HB_reset;
    logic        kch_en;
    logic [15:0] kch_fCH_ID;
    logic [15:0] kch_fCH_Hops;
    logic [15:0] kch_fCH_QValue;
    logic [15:0] kch_chosenCH;
    logic [15:0] kch_hopsFromCH;
    logic [15:0] selCH;
    logic [15:0] selHops;
    logic        sel_valid;
    logic [15:0] ch_count;
    logic        busy;

    kch_collect_ctrl #(
        .WORD_WIDTH   (16),
        .TIMER_WIDTH  (16),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .pkt_type      (pkt_type),
        .pkt_srcID     (pkt_srcID),
        .pkt_hops      (pkt_hops),
        .pkt_QValue    (pkt_QValue),
        .myNodeID      (myNodeID),
        .HB_CHlimit    (HB_CHlimit),
        .collect_window(collect_window),
        .kch_HB_reset  (kch_HB_reset),
        .kch_en        (kch_en),
        .kch_fCH_ID    (kch_fCH_ID),
        .kch_fCH_Hops  (kch_fCH_Hops),
        .kch_fCH_QValue(kch_fCH_QValue),
        .kch_chosenCH  (kch_chosenCH),
        .kch_hopsFromCH(kch_hopsFromCH),
        .selCH         (selCH),
        .selHops       (selHops),
        .sel_valid     (sel_valid),
        .ch_count      (ch_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int enSeen = 0;
    int hbSeen = 0;
    bit prevEn = 1'b0;
    bit prevHb = 1'b0;

    // Reference expectations
    bit          collecting;
    int          expCount, expEn, expHb, limit;
    logic [15:0] expFID, expFHops, expFQ;
    logic [15:0] expSelCH, expSelHops;
    bit          expSelValid;
    logic [15:0] bestID, bestHops, bestQ;

    // Store stand-in
    logic [15:0] stCH, stHops, stQ;
    assign kch_chosenCH   = stCH;
    assign kch_hopsFromCH = stHops;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stCH <= '0; stHops <= '1; stQ <= '0;
        end else if (kch_HB_reset) begin
            stCH <= '0; stHops <= '1; stQ <= '0;
        end else if (kch_en && (kch_fCH_Hops < stHops ||
                     (kch_fCH_Hops == stHops && kch_fCH_QValue > stQ))) begin
            stCH <= kch_fCH_ID; stHops <= kch_fCH_Hops; stQ <= kch_fCH_QValue;
        end
    end

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Strobe monitor: exclusivity, one-cycle width, and pulse counting.
    always @(negedge clk) begin
        checkOutput("strobe_excl", {31'd0, kch_en & kch_HB_reset}, 32'd0);
        checkOutput("en_width",    {31'd0, kch_en & prevEn}, 32'd0);
        checkOutput("hb_width",    {31'd0, kch_HB_reset & prevHb}, 32'd0);
        prevEn = kch_en;
        prevHb = kch_HB_reset;
        if (kch_en) enSeen++;
        if (kch_HB_reset) hbSeen++;
    end

    task automatic modelReset();
        collecting = 0; expCount = 0; limit = 0;
        expFID = '0; expFHops = '1; expFQ = '0;
        expSelCH = '0; expSelHops = '1; expSelValid = 0;
        bestID = '0; bestHops = '1; bestQ = '0;
    endtask

    // Present one packet; returns the cycle count of the accepting edge.
    task automatic applyStimulus(input logic [1:0] t, input logic [15:0] s,
                                 input logic [15:0] h, input logic [15:0] q,
                                 output int acc);
        int n;
        @(negedge clk);
        pkt_type = t; pkt_srcID = s; pkt_hops = h; pkt_QValue = q;
        pkt_valid = 1'b1;
        n = 0;
        while (!pkt_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pkt_ready) begin
            checkOutput("ready_timeout", {31'd0, pkt_ready}, 32'd1);
            pkt_valid = 1'b0;
            acc = -1;
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            pkt_valid = 1'b0;
        end
    endtask

    task automatic doHB(input logic [15:0] lim, input logic [15:0] win);
        int acc;
        HB_CHlimit = lim;
        collect_window = win;
        applyStimulus(2'd0, 16'd0, 16'd0, 16'd0, acc);
        expHb++; collecting = 1; expCount = 0; limit = int'(lim); expSelValid = 0;
        bestID = '0; bestHops = '1; bestQ = '0;
        checkOutput("hb_strobe", kch_HB_reset, 1);
        checkOutput("hb_busy", busy, 1);
        checkOutput("hb_ready_low", pkt_ready, 0);
        @(posedge clk); #1;
        checkOutput("hb_strobe_end", kch_HB_reset, 0);
        checkOutput("hb_count", ch_count, 0);
        checkOutput("hb_selvalid", sel_valid, 0);
        checkOutput("hb_ready_back", pkt_ready, 1);
    endtask

    task automatic doCHE(input logic [15:0] s, input logic [15:0] h,
                         input logic [15:0] q, output int acc);
        bit issue;
        issue = collecting && (s != myNodeID) && (h != 16'hFFFF) &&
                !(limit != 0 && expCount == limit);
        applyStimulus(2'd1, s, h, q, acc);
        if (issue) begin
            expEn++; expCount++;
            expFID = s; expFHops = h; expFQ = q;
            if (h < bestHops || (h == bestHops && q > bestQ)) begin
                bestID = s; bestHops = h; bestQ = q;
            end
            checkOutput("en_strobe", kch_en, 1);
            checkOutput("fch_id", kch_fCH_ID, s);
            checkOutput("fch_hops", kch_fCH_Hops, h);
            checkOutput("fch_q", kch_fCH_QValue, q);
            checkOutput("issue_ready", pkt_ready, 0);
            repeat (S) @(posedge clk);
            #1;
            checkOutput("settle_ready", pkt_ready, 0);
            checkOutput("settle_en", kch_en, 0);
            checkOutput("settle_hold_id", kch_fCH_ID, s);
            checkOutput("settle_hold_q", kch_fCH_QValue, q);
            @(posedge clk); #1;
            checkOutput("post_ready", pkt_ready, 1);
            checkOutput("post_count", ch_count, expCount);
            if (limit != 0 && expCount == limit) begin
                collecting = 0;
                expSelCH = bestID; expSelHops = bestHops; expSelValid = 1;
            end
            checkOutput("post_busy", busy, collecting);
            checkOutput("post_selvalid", sel_valid, expSelValid);
            if (!collecting) begin
                checkOutput("sel_ch", selCH, expSelCH);
                checkOutput("sel_hops", selHops, expSelHops);
            end
        end else begin
            checkOutput("drop_en", kch_en, 0);
            checkOutput("drop_count", ch_count, expCount);
            checkOutput("drop_fch_id", kch_fCH_ID, expFID);
            checkOutput("drop_fch_hops", kch_fCH_Hops, expFHops);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a1, a2, acc, hbAcc;
        int win;
        logic [15:0] s, h, q;

        modelReset();
        expEn = 0; expHb = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", pkt_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_hb", kch_HB_reset, 0);
        checkOutput("rst_en", kch_en, 0);
        checkOutput("rst_fch_id", kch_fCH_ID, 16'h0000);
        checkOutput("rst_fch_hops", kch_fCH_Hops, 16'hFFFF);
        checkOutput("rst_selhops", selHops, 16'hFFFF);
        checkOutput("rst_selvalid", sel_valid, 0);
        checkOutput("rst_count", ch_count, 0);
        @(negedge clk);
        nrst = 1'b1;

        // CHE in IDLE is dropped
        doCHE(16'd9, 16'd1, 16'h1000, acc);

        // Round with limit 3, window 100
        $display("[TB] limit-3 round");
        doHB(16'd3, 16'd100);
        doCHE(16'd23, 16'd2, 16'h3000, a1);
        doCHE(16'd45, 16'd2, 16'h2000, a2);
        checkOutput("en_gap_ok", (a2 - a1 >= 1 + S), 1);
        checkOutput("count_two", ch_count, 2);
        doCHE(16'd6, 16'd1, 16'h4000, acc);
        checkOutput("sel_ch_6", selCH, 16'd6);
        checkOutput("sel_hops_1", selHops, 16'd1);
        doCHE(16'd77, 16'd1, 16'h1000, acc);
        checkOutput("en_total_a", enSeen, expEn);

        // Self-advert and unreachable advert filtering
        $display("[TB] filtering");
        doHB(16'd0, 16'd0);
        doCHE(16'd12, 16'd1, 16'h2000, acc);
        doCHE(16'd30, 16'hFFFF, 16'h2000, acc);
        doCHE(16'd31, 16'd4, 16'h1800, acc);
        checkOutput("en_total_b", enSeen, expEn);

        // Window expiry with no CHE
        $display("[TB] window expiry");
        win = 10;
        doHB(16'd0, 16'(win));
        repeat (win) @(posedge clk);
        #1;
        checkOutput("win_busy_before", busy, 1);
        @(posedge clk); #1;
        collecting = 0; expSelCH = '0; expSelHops = '1; expSelValid = 0;
        checkOutput("win_busy_after", busy, 0);
        checkOutput("win_selvalid", sel_valid, 0);
        checkOutput("win_count", ch_count, 0);
        checkOutput("win_selhops", selHops, 16'hFFFF);

        // Randomized round
        $display("[TB] randomized round");
        doHB(16'($urandom_range(2, 4)), 16'd0);
        for (int i = 0; i < 8; i++) begin
            s = ($urandom_range(0, 4) == 0) ? 16'd12 : 16'($urandom_range(1, 200));
            h = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom_range(1, 8));
            q = 16'($urandom_range(0, 16'h4000));
            doCHE(s, h, q, acc);
        end
        checkOutput("en_total_c", enSeen, expEn);

        // HB during SETTLE is held off until COLLECT
        $display("[TB] HB during settle");
        doHB(16'd0, 16'd0);
        applyStimulus(2'd1, 16'd77, 16'd3, 16'h2200, a1);
        expEn++; expCount++;
        checkOutput("ms_en", kch_en, 1);
        HB_CHlimit = 16'd0; collect_window = 16'd0;
        applyStimulus(2'd0, 16'd0, 16'd0, 16'd0, hbAcc);
        expHb++; expCount = 0; expSelValid = 0;
        checkOutput("ms_holdoff", hbAcc - a1, 2 + S);
        checkOutput("ms_hb", kch_HB_reset, 1);
        @(posedge clk); #1;
        checkOutput("ms_selvalid", sel_valid, 0);
        checkOutput("ms_count", ch_count, 0);

        // Abort in ISSUE
        $display("[TB] reset in ISSUE");
        applyStimulus(2'd1, 16'd55, 16'd2, 16'h3100, acc);
        checkOutput("ab_issue", kch_en, 1);
        nrst = 1'b0;
        #1;
        modelReset();
        checkOutput("ab_en", kch_en, 0);
        checkOutput("ab_hb", kch_HB_reset, 0);
        checkOutput("ab_ready", pkt_ready, 1);
        checkOutput("ab_busy", busy, 0);
        checkOutput("ab_fch_id", kch_fCH_ID, expFID);
        checkOutput("ab_fch_hops", kch_fCH_Hops, expFHops);
        checkOutput("ab_fch_q", kch_fCH_QValue, expFQ);
        checkOutput("ab_selch", selCH, expSelCH);
        checkOutput("ab_selhops", selHops, expSelHops);
        checkOutput("ab_count", ch_count, 0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("ab_idle_busy", busy, 0);
        checkOutput("ab_en_total", enSeen, expEn);
        checkOutput("ab_hb_total", hbSeen, expHb);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
